// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// ASCII constants also used by the transmit-side string generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] TICK_A     = 4'd7;
  localparam logic [3:0] TICK_B     = 4'd8;
  localparam logic [3:0] TICK_C     = 4'd9;
  localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0d;
  localparam logic [7:0] LF    = 8'h0a;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO: head byte is presented combinationally while valid.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop_ok;
  logic        push_ok;

  assign level   = wr_ptr - rd_ptr;
  assign valid   = (level != '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign pop_ok  = pop & valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Gated so the read port shows 0 while empty, including straight after reset.
  assign rd_data = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote, a
// show-ahead receive FIFO and sticky framing/overrun flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                   SYSCLK,
  input  logic                   RST_B,
  input  logic                   UART_RX_I,
  input  logic                   RD_EN,
  input  logic                   CLR_ERR,
  output logic [7:0]             RD_DATA,
  output logic                   RD_VALID,
  output logic                   FIFO_FULL,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN,
  output logic                   RX_BUSY
);

  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic          rx_m, rx_s, rx_prev;
  logic [CW-1:0] div_cnt;
  logic          tick;
  rx_state_t     state, state_n;
  logic [3:0]    s_cnt, s_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    votes, votes_n;
  logic          maj_all, maj_now;
  logic          push, frame_set, start_edge, drop;

  // Synchronizer resets to the idle level so reset release is not a start edge.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= UART_RX_I;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign tick = (div_cnt == '0);

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B)                div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= CW'(DIV - 1);
    else                       div_cnt <= div_cnt - CW'(1);
  end

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state   <= IDLE;
      s_cnt   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      votes   <= '1;
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      votes   <= votes_n;
    end
  end

  // At tick 15 all three votes are stored; at stop tick 9 the third is rx_s.
  assign maj_all = maj3(votes[0], votes[1], votes[2]);
  assign maj_now = maj3(votes[0], votes[1], rx_s);

  always_comb begin
    state_n    = state;
    s_cnt_n    = s_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    votes_n    = votes;
    push       = 1'b0;
    frame_set  = 1'b0;
    start_edge = 1'b0;
    if (tick && (state inside {START, DATA, STOP})) begin
      s_cnt_n = s_cnt + 4'd1;
      if (s_cnt == TICK_A) votes_n[0] = rx_s;
      if (s_cnt == TICK_B) votes_n[1] = rx_s;
      if (s_cnt == TICK_C) votes_n[2] = rx_s;
    end
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n    = START;
          s_cnt_n    = 4'd0;
          start_edge = 1'b1;
        end
      end
      START: begin
        if (tick && s_cnt == TICK_LAST) begin
          state_n   = maj_all ? IDLE : DATA;
          bit_idx_n = 3'd0;
        end
      end
      DATA: begin
        if (tick && s_cnt == TICK_LAST) begin
          shreg_n   = {maj_all, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so the next start edge can arrive early.
        if (tick && s_cnt == TICK_C) begin
          if (maj_now) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_set = 1'b1;
            state_n   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign RX_BUSY = (state != IDLE);

  // Read port: a byte is consumed in any cycle where RD_VALID and RD_EN are
  // both high; RD_EN is ignored while RD_VALID is low.
  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (SYSCLK),
    .rst_b     (RST_B),
    .push      (push),
    .push_data (shreg),
    .pop       (RD_EN),
    .rd_data   (RD_DATA),
    .valid     (RD_VALID),
    .full      (FIFO_FULL),
    .level     (LEVEL),
    .drop      (drop)
  );

  // A new error in the same cycle as CLR_ERR wins.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_set | (FRAME_ERR & ~CLR_ERR);
      OVERRUN   <= drop      | (OVERRUN   & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 16 clocks per bit (DIV=1).
// Frames are driven bit by bit; received bytes are checked against exp_q.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       sysclk = 1'b0;
  logic       rst_b;
  logic       uart_rx_i;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_full;
  logic [4:0] level;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         total_cnt = 0;
  int         fv;
  int         busy_len;
  logic [7:0] exp_q[$];
  logic [7:0] msg [15] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, SPACE, 8'h77,
                           8'h6f, 8'h72, 8'h6c, 8'h64, SPACE, 8'h21, CR, LF};

  uart_rx_buffered #(.CLK_HZ(16000000), .BAUD(1000000), .DEPTH(DEPTH)) dut (
    .SYSCLK    (sysclk),
    .RST_B     (rst_b),
    .UART_RX_I (uart_rx_i),
    .RD_EN     (rd_en),
    .CLR_ERR   (clr_err),
    .RD_DATA   (rd_data),
    .RD_VALID  (rd_valid),
    .FIFO_FULL (fifo_full),
    .LEVEL     (level),
    .FRAME_ERR (frame_err),
    .OVERRUN   (overrun),
    .RX_BUSY   (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick_n(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives ncyc cycles of an 8N1 frame; RD_EN pulses in cycle pop_at.
  // first_valid = first cycle count after which RD_VALID was seen high.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_at,
                            input int ncyc, output int first_valid);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    first_valid = -1;
    for (int c = 0; c < ncyc; c++) begin
      uart_rx_i = bits[c/16];
      rd_en     = (c == pop_at);
      tick_n(1);
      if (rd_valid && first_valid < 0) first_valid = c + 1;
    end
    rd_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] data);
    int f;
    send_frame(data, 1'b1, -1, 160, f);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    tick_n(1);
    rd_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},  32'(rd_data),   32'd0);
    check({tag, "_valid"}, 32'(rd_valid),  32'd0);
    check({tag, "_full"},  32'(fifo_full), 32'd0);
    check({tag, "_level"}, 32'(level),     32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_ovr"},   32'(overrun),   32'd0);
    check({tag, "_busy"},  32'(rx_busy),   32'd0);
  endtask

  initial begin
    rst_b     = 1'b0;
    uart_rx_i = 1'b1;
    rd_en     = 1'b0;
    clr_err   = 1'b0;
    tick_n(3);
    check_idle_outputs("reset");
    rst_b = 1'b1;
    tick_n(5);
    check_idle_outputs("post_reset");

    // 1: single frame; 2 sync + 1 edge detect + 9*16 bits + 9 ticks + 1 FIFO = 157
    send_frame(8'h68, 1'b1, -1, 160, fv);
    check("t1_latency", 32'(fv), 32'd157);
    check("t1_level", 32'(level), 32'd1);
    exp_q.push_back(8'h68);
    read_check("t1_rd");
    check("t1_empty", 32'(rd_valid), 32'd0);
    check("t1_ferr", 32'(frame_err), 32'd0);

    // 2: back-to-back message, then drain
    for (int i = 0; i < 15; i++) begin
      send(msg[i]);
      exp_q.push_back(msg[i]);
    end
    check("t2_level", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) read_check($sformatf("t2_rd%0d", i));
    check("t2_empty", 32'(rd_valid), 32'd0);

    // 3a: 17 frames into 16 entries; the 17th (0x10) is dropped
    for (int i = 0; i < 17; i++) send(8'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_level", 32'(level), 32'd16);
    check("t3_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) read_check($sformatf("t3_rd%0d", i));
    check("t3_empty", 32'(rd_valid), 32'd0);
    clr_err = 1'b1;
    tick_n(1);
    clr_err = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);

    // 3b: pop in the push cycle of the 17th frame, so nothing is lost
    for (int i = 0; i < 16; i++) send(8'(i));
    send_frame(8'h10, 1'b1, 156, 160, fv);
    for (int i = 1; i < 17; i++) exp_q.push_back(8'(i));
    check("t3b_full", 32'(fifo_full), 32'd1);
    check("t3b_level", 32'(level), 32'd16);
    check("t3b_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) read_check($sformatf("t3b_rd%0d", i));

    // 4: framing error followed by a long low line
    send_frame(8'h55, 1'b0, -1, 160, fv);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_level", 32'(level), 32'd0);
    uart_rx_i = 1'b0;
    tick_n(640);
    check("t4_busy_low", 32'(rx_busy), 32'd1);
    check("t4_level_low", 32'(level), 32'd0);
    uart_rx_i = 1'b1;
    tick_n(20);
    check("t4_idle", 32'(rx_busy), 32'd0);
    check("t4_no_byte", 32'(level), 32'd0);
    send(8'h41);
    exp_q.push_back(8'h41);
    check("t4_level2", 32'(level), 32'd1);
    read_check("t4_rd");
    check("t4_ferr_kept", 32'(frame_err), 32'd1);
    clr_err = 1'b1;
    tick_n(1);
    clr_err = 1'b0;
    check("t4_ferr_clr", 32'(frame_err), 32'd0);

    // 5: 4-cycle start glitch; START is held for 16 cycles then aborts
    busy_len = 0;
    for (int c = 0; c < 40; c++) begin
      uart_rx_i = (c < 4) ? 1'b0 : 1'b1;
      tick_n(1);
      if (rx_busy) busy_len++;
    end
    check("t5_busy_len", 32'(busy_len), 32'd16);
    check("t5_busy_end", 32'(rx_busy), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_ovr", 32'(overrun), 32'd0);

    // 6: reset in the middle of data bit 3 of 0xA5
    send(8'h77);
    check("t6_pre_level", 32'(level), 32'd1);
    send_frame(8'hA5, 1'b1, -1, 72, fv);
    check("t6_pre_busy", 32'(rx_busy), 32'd1);
    rst_b = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    uart_rx_i = 1'b1;
    tick_n(4);
    rst_b = 1'b1;
    tick_n(4);
    check_idle_outputs("t6_release");
    send(8'h3C);
    exp_q.push_back(8'h3C);
    check("t6_level", 32'(level), 32'd1);
    read_check("t6_rd");
    check("t6_ferr", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
